// File: rtl/fifo_pkg.sv
// Shared FSM encoding and line constants for the FIFO serial drain.
package fifo_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_START = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_STOP  = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        REQ   = ST_REQ,
        WAIT  = ST_WAIT,
        START = ST_START,
        DATA  = ST_DATA,
        STOP  = ST_STOP
    } state_t;

    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/fifo_serial_drain_if.sv
// FIFO read port plus serial line bundle; master is the drain, slave the environment.
interface fifo_serial_drain_if #(
    parameter int DATO_WIDTH = 3
);
    logic                  en;
    logic                  empy;
    logic [DATO_WIDTH-1:0] datout;
    logic                  rclk;
    logic                  tx;
    logic                  busy;
    logic                  done;
    logic [7:0]            sent;

    modport master (
        input  en, empy, datout,
        output rclk, tx, busy, done, sent
    );

    modport slave (
        output en, empy, datout,
        input  rclk, tx, busy, done, sent
    );
endinterface

// File: rtl/fifo_bit_timer.sv
// Bit-period counter: tick marks the last clk of each CLKS_PER_BIT-long bit.
module fifo_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic tick
);
    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_reg;

    assign tick = run && (cnt_reg == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_reg <= '0;
        end else if (run) begin
            cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
        end
    end
endmodule

// File: rtl/fifo_serial_drain.sv
// Pops one word from the FIFO read port and sends it as start / LSB-first data / stop.
module fifo_serial_drain
    import fifo_pkg::*;
#(
    parameter int DATO_WIDTH   = 3,
    parameter int CLKS_PER_BIT = 4,
    parameter int READ_LAT     = 1
) (
    input  logic                clk,
    input  logic                rst,
    fifo_serial_drain_if.master bus
);
    localparam int            BW        = $clog2(DATO_WIDTH + 1);
    localparam int            LW        = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATO_WIDTH - 1);
    localparam logic [LW-1:0] LAST_WAIT = LW'(READ_LAT - 1);

    state_t                state_reg, state_next;
    logic [DATO_WIDTH-1:0] shift_reg, shift_next;
    logic [BW-1:0]         bit_reg, bit_next;
    logic [LW-1:0]         wait_reg, wait_next;
    logic [7:0]            sent_reg, sent_next;
    logic                  tx_reg, tx_next;
    logic                  rclk_reg, rclk_next;
    logic                  busy_reg, busy_next;
    logic                  done_reg, done_next;
    logic                  tick, timer_run, timer_clear;

    assign timer_run   = state_reg inside {START, DATA, STOP};
    assign timer_clear = (state_next != state_reg);

    fifo_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(timer_clear),
        .run  (timer_run),
        .tick (tick)
    );

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        bit_next   = bit_reg;
        wait_next  = wait_reg;
        sent_next  = sent_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE:  if (bus.en && !bus.empy) state_next = REQ;
            REQ:   state_next = WAIT;
            WAIT: begin
                // The read is already committed, so empy is ignored from here on.
                if (wait_reg == LAST_WAIT) begin
                    shift_next = bus.datout;
                    state_next = START;
                end else begin
                    wait_next = wait_reg + 1'b1;
                end
            end
            START: if (tick) state_next = DATA;
            DATA: begin
                if (tick) begin
                    shift_next = shift_reg >> 1;
                    if (bit_reg == LAST_BIT) state_next = STOP;
                    else                     bit_next   = bit_reg + 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    sent_next  = sent_reg + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (state_next != state_reg) begin
            bit_next  = '0;
            wait_next = '0;
        end

        // Outputs are decoded from the next state so the registers line up with it.
        rclk_next = (state_next == REQ);
        busy_next = (state_next != IDLE);
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            bit_reg   <= '0;
            wait_reg  <= '0;
            sent_reg  <= '0;
            tx_reg    <= LINE_IDLE;
            rclk_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            bit_reg   <= bit_next;
            wait_reg  <= wait_next;
            sent_reg  <= sent_next;
            tx_reg    <= tx_next;
            rclk_reg  <= rclk_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign bus.rclk = rclk_reg;
    assign bus.tx   = tx_reg;
    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.sent = sent_reg;
endmodule
